// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: drives a radix-2 in-place DIT FFT over one butterfly
// unit and a dual-port sample RAM. One butterfly is read per ISSUE cycle; the
// twiddle angle and the write-back addresses ride delay lines so that they
// line up with the RAM read data and with the butterfly output respectively.
// After each stage the read+CORDIC pipeline drains completely, so the next
// stage only ever reads samples that have already been written back.
//
// Handshake: start_i is a plain level sampled only while IDLE (one cycle high
// is enough, extra cycles outside IDLE are ignored). There is no backpressure:
// once started, the RAM and butterfly must accept one operation per ISSUE
// cycle, and rd_en_o / wr_en_o are single-cycle strobes, one per butterfly.
module fft_stage_sequencer #(
   parameter  int N_LOG2     = 4,
   parameter  int FRAC_BITS  = 15,
   parameter  int RD_LAT     = 1,
   parameter  int CORDIC_LAT = 16,
   localparam int SW         = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1,
   localparam int TW         = FRAC_BITS + 1
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [SW-1:0]     stage_o,
   output logic              rd_en_o,
   output logic [N_LOG2-1:0] rd_addr_a_o,
   output logic [N_LOG2-1:0] rd_addr_b_o,
   output logic [TW-1:0]     twid_o,
   output logic              wr_en_o,
   output logic [N_LOG2-1:0] wr_addr_a_o,
   output logic [N_LOG2-1:0] wr_addr_b_o,
   output logic [1:0]        state_o
);

   localparam int LAT = RD_LAT + CORDIC_LAT;
   localparam int KW  = N_LOG2 - 1;
   localparam int DW  = $clog2(LAT + 1);

   // FSM encoding; IDLE is all-zero so the debug state reads 0 out of reset.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);
   localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

   logic [1:0]    state_q;
   logic [SW-1:0] stage_q;
   logic [KW-1:0] k_q;
   logic [DW-1:0] drain_q;

   logic [N_LOG2-1:0] k_ext;
   logic [N_LOG2-1:0] half_c;
   logic [N_LOG2-1:0] j_c;
   logic [N_LOG2-1:0] g_base_c;
   logic [N_LOG2-1:0] addr_a_c;
   logic [N_LOG2-1:0] addr_b_c;
   logic [SW-1:0]     m_sh_c;
   logic [TW-1:0]     m_ext;
   logic [TW-1:0]     twid_c;

   // Twiddle delay line: valid + angle, RD_LAT deep, last element holds.
   logic          tv_q [RD_LAT];
   logic [TW-1:0] tw_q [RD_LAT];

   // Write-back delay line: valid + both addresses, LAT deep.
   logic              wv_q [LAT];
   logic [N_LOG2-1:0] wa_q [LAT];
   logic [N_LOG2-1:0] wb_q [LAT];

   // Stage / butterfly / drain sequencing.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_ISSUE;
                  stage_q <= '0;
                  k_q     <= '0;
               end
            end
            S_ISSUE: begin
               if (k_q == K_LAST) begin
                  state_q <= S_DRAIN;
                  drain_q <= '0;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            S_DRAIN: begin
               if (drain_q == D_LAST) begin
                  if (stage_q == S_LAST) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_ISSUE;
                     stage_q <= stage_q + SW'(1);
                     k_q     <= '0;
                  end
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Butterfly addressing and twiddle angle for (stage_q, k_q).
   // addr_a = g*2*half + j is k with its upper bits (above the stage bit)
   // shifted left by one; addr_b sets the stage bit, which is always clear in
   // addr_a. The angle is -m/N of a turn, formed as an unsigned wrap-around.
   always_comb begin
      k_ext    = {1'b0, k_q};
      half_c   = N_LOG2'(1) << stage_q;
      j_c      = k_ext & (half_c - N_LOG2'(1));
      g_base_c = (k_ext & ~(half_c - N_LOG2'(1))) << 1;
      addr_a_c = g_base_c | j_c;
      addr_b_c = addr_a_c | half_c;
      m_sh_c   = S_LAST - stage_q;
      m_ext    = TW'(j_c << m_sh_c);
      twid_c   = TW'(0) - (m_ext << (TW - N_LOG2));
   end

   // Twiddle alignment: the angle reaches twid_o RD_LAT cycles after its read
   // and stays there until the next butterfly's angle arrives.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tv_q[i] <= 1'b0;
            tw_q[i] <= '0;
         end
      end else begin
         tv_q[0] <= rd_en_o;
         if (RD_LAT == 1) begin
            if (rd_en_o) tw_q[0] <= twid_c;
         end else begin
            tw_q[0] <= twid_c;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            tv_q[i] <= tv_q[i-1];
            if (i == RD_LAT - 1) begin
               if (tv_q[i-1]) tw_q[i] <= tw_q[i-1];
            end else begin
               tw_q[i] <= tw_q[i-1];
            end
         end
      end
   end

   // Write-back alignment: addresses enter already zeroed when no read is
   // issued, so idle slots come out with wr_addr_* = 0.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            wv_q[i] <= 1'b0;
            wa_q[i] <= '0;
            wb_q[i] <= '0;
         end
      end else begin
         wv_q[0] <= rd_en_o;
         wa_q[0] <= rd_addr_a_o;
         wb_q[0] <= rd_addr_b_o;
         for (int i = 1; i < LAT; i++) begin
            wv_q[i] <= wv_q[i-1];
            wa_q[i] <= wa_q[i-1];
            wb_q[i] <= wb_q[i-1];
         end
      end
   end

   // Output decode straight from registered state, so reset clears them at once.
   always_comb begin
      rd_en_o     = (state_q == S_ISSUE);
      rd_addr_a_o = rd_en_o ? addr_a_c : '0;
      rd_addr_b_o = rd_en_o ? addr_b_c : '0;
      busy_o      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      done_o      = (state_q == S_DONE);
      stage_o     = stage_q;
      state_o     = state_q;
      twid_o      = tw_q[RD_LAT-1];
      wr_en_o     = wv_q[LAT-1];
      wr_addr_a_o = wa_q[LAT-1];
      wr_addr_b_o = wb_q[LAT-1];
   end

endmodule
